// File: rtl/axi4_pkg.sv
// Shared constants, state encoding and the burst-legality test for the AXI4
// slave-to-mm bridge.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    localparam logic [2:0] SIZE_WORD   = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_DATA,
        S_W_RMW_RD,
        S_W_MM,
        S_W_RESP,
        S_R_MM,
        S_R_DATA
    } state_t;

    // Only word-sized FIXED/INCR bursts reach the mm bus; the reserved burst
    // encoding is refused the same way as WRAP.
    function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_WORD) || (burst == BURST_WRAP) || (burst == 2'd3);
    endfunction

endpackage

// File: rtl/axi4_burst_addr.sv
// Word address and beat counter for the burst in flight; shared by the read
// and write paths since only one burst is ever active.
module axi4_burst_addr
    import axi4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] load_addr,
    input  logic [7:0]  load_len,
    input  logic [1:0]  load_burst,
    output logic [31:0] addr,
    output logic [7:0]  beat,
    output logic        last
);

    logic [31:0] addr_reg;
    logic [7:0]  beat_reg;
    logic [7:0]  len_reg;
    logic        fixed_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg  <= '0;
            beat_reg  <= '0;
            len_reg   <= '0;
            fixed_reg <= 1'b0;
        end else if (load) begin
            addr_reg  <= {load_addr[31:2], 2'b00};
            beat_reg  <= '0;
            len_reg   <= load_len;
            fixed_reg <= (load_burst == BURST_FIXED);
        end else if (step && !last) begin
            // Counter stops at len, so a 256-beat burst never wraps it.
            beat_reg <= beat_reg + 8'd1;
            if (!fixed_reg) begin
                addr_reg <= addr_reg + 32'd4;
            end
        end
    end

    assign addr = addr_reg;
    assign beat = beat_reg;
    assign last = (beat_reg == len_reg);

endmodule

// File: rtl/axi42mm.sv
// AXI4 slave that replays bursts one word at a time on the pCPU mm bus,
// emulating byte strobes with a read-modify-write.
module axi42mm
    import axi4_pkg::*;
#(
    parameter int AXI4_IDLEN   = 12,
    parameter int AXI4_ADDRLEN = 32,
    parameter int AXI4_DATALEN = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI4_IDLEN-1:0]     s_axi_awid,
    input  logic [AXI4_ADDRLEN-1:0]   s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awlock,
    input  logic [3:0]                s_axi_awcache,
    input  logic [2:0]                s_axi_awprot,
    input  logic [3:0]                s_axi_awqos,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI4_DATALEN-1:0]   s_axi_wdata,
    input  logic [AXI4_DATALEN/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [AXI4_IDLEN-1:0]     s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI4_IDLEN-1:0]     s_axi_arid,
    input  logic [AXI4_ADDRLEN-1:0]   s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arlock,
    input  logic [3:0]                s_axi_arcache,
    input  logic [2:0]                s_axi_arprot,
    input  logic [3:0]                s_axi_arqos,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI4_IDLEN-1:0]     s_axi_rid,
    output logic [AXI4_DATALEN-1:0]   s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [31:0]               a,
    output logic [31:0]               d,
    output logic                      we,
    output logic                      rd,
    input  logic [31:0]               spo,
    input  logic                      ready
);

    state_t                  state_reg, state_next;
    logic                    prefer_w_reg;
    logic [AXI4_IDLEN-1:0]   id_reg;
    logic                    err_reg;
    logic                    wlast_err_reg;
    logic [31:0]             data_reg;
    logic [3:0]              strb_reg;
    logic [31:0]             rdata_reg;
    logic [31:0]             merged;

    logic                    aw_hs, ar_hs, w_hs;
    logic                    burst_load, burst_step;
    logic [31:0]             aw_addr32, ar_addr32;
    logic [31:0]             cur_addr;
    logic [7:0]              cur_beat;
    logic                    last;

    logic                    unused_sideband;
    assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, cur_beat};

    assign aw_addr32 = 32'(s_axi_awaddr);
    assign ar_addr32 = 32'(s_axi_araddr);

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;

    axi4_burst_addr u_burst_addr (
        .clk        (clk),
        .rst        (rst),
        .load       (burst_load),
        .step       (burst_step),
        .load_addr  (aw_hs ? aw_addr32 : ar_addr32),
        .load_len   (aw_hs ? s_axi_awlen : s_axi_arlen),
        .load_burst (aw_hs ? s_axi_awburst : s_axi_arburst),
        .addr       (cur_addr),
        .beat       (cur_beat),
        .last       (last)
    );

    // Strobed bytes come from the AXI beat, the rest from the mm read-back.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged[gi*8 +: 8] = strb_reg[gi] ? data_reg[gi*8 +: 8] : spo[gi*8 +: 8];
    end

    always_comb begin
        state_next    = state_reg;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_rvalid  = 1'b0;
        we            = 1'b0;
        rd            = 1'b0;
        burst_load    = 1'b0;
        burst_step    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (s_axi_awvalid && (!s_axi_arvalid || prefer_w_reg)) begin
                    s_axi_awready = 1'b1;
                    burst_load    = 1'b1;
                    state_next    = S_W_DATA;
                end else if (s_axi_arvalid) begin
                    s_axi_arready = 1'b1;
                    burst_load    = 1'b1;
                    state_next    = S_R_MM;
                end
            end
            S_W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    if (err_reg || (s_axi_wstrb == '0)) begin
                        if (last) begin
                            state_next = S_W_RESP;
                        end else begin
                            burst_step = 1'b1;
                        end
                    end else if (s_axi_wstrb == '1) begin
                        state_next = S_W_MM;
                    end else begin
                        state_next = S_W_RMW_RD;
                    end
                end
            end
            S_W_RMW_RD: begin
                rd = 1'b1;
                if (ready) begin
                    state_next = S_W_MM;
                end
            end
            S_W_MM: begin
                we = 1'b1;
                if (ready) begin
                    if (last) begin
                        state_next = S_W_RESP;
                    end else begin
                        burst_step = 1'b1;
                        state_next = S_W_DATA;
                    end
                end
            end
            S_W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    state_next = S_IDLE;
                end
            end
            S_R_MM: begin
                // Error bursts produce zero data without touching the bus.
                if (err_reg) begin
                    state_next = S_R_DATA;
                end else begin
                    rd = 1'b1;
                    if (ready) begin
                        state_next = S_R_DATA;
                    end
                end
            end
            S_R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) begin
                    if (last) begin
                        state_next = S_IDLE;
                    end else begin
                        burst_step = 1'b1;
                        state_next = S_R_MM;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            prefer_w_reg  <= 1'b1;
            id_reg        <= '0;
            err_reg       <= 1'b0;
            wlast_err_reg <= 1'b0;
            data_reg      <= '0;
            strb_reg      <= '0;
            rdata_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (aw_hs) begin
                id_reg        <= s_axi_awid;
                err_reg       <= burst_bad(s_axi_awsize, s_axi_awburst);
                wlast_err_reg <= 1'b0;
                prefer_w_reg  <= 1'b0;
            end else if (ar_hs) begin
                id_reg       <= s_axi_arid;
                err_reg      <= burst_bad(s_axi_arsize, s_axi_arburst);
                prefer_w_reg <= 1'b1;
            end
            if (w_hs) begin
                data_reg <= s_axi_wdata;
                strb_reg <= s_axi_wstrb;
                if (s_axi_wlast != last) begin
                    wlast_err_reg <= 1'b1;
                end
            end
            if ((state_reg == S_W_RMW_RD) && ready) begin
                data_reg <= merged;
            end
            if ((state_reg == S_R_MM) && (err_reg || ready)) begin
                rdata_reg <= err_reg ? 32'd0 : spo;
            end
        end
    end

    assign a           = cur_addr;
    assign d           = data_reg;
    assign s_axi_bid   = id_reg;
    assign s_axi_rid   = id_reg;
    assign s_axi_rdata = rdata_reg;
    assign s_axi_rlast = (state_reg == S_R_DATA) && last;
    assign s_axi_bresp = ((state_reg == S_W_RESP) && (err_reg || wlast_err_reg)) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rresp = ((state_reg == S_R_DATA) && err_reg) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi42mm.sv
// Directed bench for axi42mm: an mm responder with programmable wait states
// logs every completed write while one initial block drives the AXI side.
module tb_axi42mm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] awid = '0, arid = '0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = 3'd2, arsize = 3'd2;
    logic [1:0]  awburst = 2'd1, arburst = 2'd1;
    logic        awvalid = 1'b0, arvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0;
    logic        bready = 1'b0, rready = 1'b0;
    logic        awready, arready, wready, bvalid, rvalid, rlast;
    logic [11:0] bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, a, d, spo;
    logic        we, rd, ready;

    logic [31:0] spo_val = '0;
    int          wait_cycles = 0;
    int          wait_cnt = 0;
    int          wr_count = 0, rd_count = 0, both_count = 0;
    logic [31:0] wr_addr_log [64];
    logic [31:0] wr_data_log [64];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi42mm dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
        .s_axi_awqos(4'd0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
        .s_axi_arqos(4'd0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready)
    );

    // mm responder: ready rises after wait_cycles cycles of a held request.
    assign spo   = spo_val;
    assign ready = (rd || we) && (wait_cnt >= wait_cycles);

    always @(posedge clk) begin
        if (we && ready) begin
            wr_addr_log[wr_count % 64] <= a;
            wr_data_log[wr_count % 64] <= d;
            wr_count <= wr_count + 1;
        end
        if (rd && ready) rd_count <= rd_count + 1;
        if (we && rd) both_count <= both_count + 1;
        if ((rd || we) && !ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_go(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        logic got = 1'b0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            got = awready;
            step();
        end
        awvalid = 1'b0;
        check("aw_handshake", got, 1);
    endtask

    task automatic ar_go(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        logic got = 1'b0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            got = arready;
            step();
        end
        arvalid = 1'b0;
        check("ar_handshake", got, 1);
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic lst);
        logic got = 1'b0;
        wdata = data; wstrb = strb; wlast = lst; wvalid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            got = wready;
            step();
        end
        wvalid = 1'b0;
        check("w_handshake", got, 1);
    endtask

    task automatic b_take(output logic [1:0] resp, output logic [11:0] id);
        logic got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (bvalid === 1'b1) got = 1'b1;
            else step();
        end
        check("b_wait", got, 1);
        resp = bresp; id = bid;
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic r_take(output logic [31:0] data, output logic [1:0] resp,
                          output logic lst, output logic [11:0] id);
        logic got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (rvalid === 1'b1) got = 1'b1;
            else step();
        end
        check("r_wait", got, 1);
        data = rdata; resp = rresp; lst = rlast; id = rid;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [11:0] id;
        logic [31:0] data;
        logic        lst;
        int          base, rbase;

        // Reset state
        step(); step(); #1;
        check("rst_ready", {awready, arready, wready}, 0);
        check("rst_valid", {bvalid, rvalid, rlast}, 0);
        check("rst_mm", {we, rd}, 0);
        check("rst_a", a, 0);
        check("rst_d", d, 0);
        check("rst_rdata", rdata, 0);
        check("rst_ids", {bid, rid}, 0);
        check("rst_resp", {bresp, rresp}, 0);
        step();
        rst = 1'b1;
        step();

        // Contention from reset: write first, then read; twice in a row
        for (int k = 0; k < 2; k++) begin
            spo_val = 32'h55AA_55AA + k;
            awid = 12'd1; awaddr = 32'h40; awlen = 0; awsize = 2; awburst = 1; awvalid = 1'b1;
            arid = 12'd2; araddr = 32'h80; arlen = 0; arsize = 2; arburst = 1; arvalid = 1'b1;
            #1;
            check("arb_w_first_aw", awready, 1);
            check("arb_w_first_ar", arready, 0);
            step();
            awvalid = 1'b0;
            w_beat(32'h11, 4'hF, 1'b1);
            b_take(resp, id);
            check("arb_bresp", resp, 0);
            check("arb_bid", id, 12'd1);
            #1;
            check("arb_r_next", arready, 1);
            step();
            arvalid = 1'b0;
            r_take(data, resp, lst, id);
            check("arb_rdata", data, 32'h55AA_55AA + k);
            check("arb_rid", id, 12'd2);
        end

        // Single read, zero wait: rd at cycle 1, rvalid at cycle 2
        spo_val = 32'hDEAD_BEEF;
        arid = 12'd5; araddr = 32'h100; arlen = 0; arsize = 2; arburst = 1; arvalid = 1'b1;
        #1;
        check("rd1_arready", arready, 1);
        step();
        arvalid = 1'b0;
        #1;
        check("rd1_rd", rd, 1);
        check("rd1_a", a, 32'h100);
        check("rd1_rvalid_early", rvalid, 0);
        step();
        check("rd1_rd_drop", rd, 0);
        check("rd1_rvalid", rvalid, 1);
        check("rd1_rlast", rlast, 1);
        check("rd1_rdata", rdata, 32'hDEAD_BEEF);
        check("rd1_rresp", rresp, 0);
        check("rd1_rid", rid, 12'd5);
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("rd1_done", rvalid, 0);

        // INCR write len 3 with two wait cycles per access
        base = wr_count;
        wait_cycles = 2;
        aw_go(12'hABC, 32'h200, 8'd3, 3'd2, 2'd1);
        w_beat(32'd1, 4'hF, 1'b0);
        #1;
        check("wr_we_next_cycle", we, 1);
        w_beat(32'd2, 4'hF, 1'b0);
        w_beat(32'd3, 4'hF, 1'b0);
        w_beat(32'd4, 4'hF, 1'b1);
        b_take(resp, id);
        check("incr_bresp", resp, 0);
        check("incr_bid", id, 12'hABC);
        check("incr_count", wr_count - base, 4);
        for (int k = 0; k < 4; k++) begin
            check("incr_addr", wr_addr_log[(base + k) % 64], 32'h200 + 4 * k);
            check("incr_data", wr_data_log[(base + k) % 64], k + 1);
        end
        wait_cycles = 0;

        // Partial strobe: read-modify-write; empty strobe: no mm access
        spo_val = 32'h1234_5678;
        base = wr_count; rbase = rd_count;
        aw_go(12'd3, 32'h300, 8'd0, 3'd2, 2'd1);
        w_beat(32'h0000_ABCD, 4'h3, 1'b1);
        b_take(resp, id);
        check("rmw_bresp", resp, 0);
        check("rmw_reads", rd_count - rbase, 1);
        check("rmw_writes", wr_count - base, 1);
        check("rmw_addr", wr_addr_log[base % 64], 32'h300);
        check("rmw_data", wr_data_log[base % 64], 32'h1234_ABCD);
        base = wr_count; rbase = rd_count;
        aw_go(12'd4, 32'h304, 8'd0, 3'd2, 2'd1);
        w_beat(32'hFFFF_FFFF, 4'h0, 1'b1);
        b_take(resp, id);
        check("nostrb_bresp", resp, 0);
        check("nostrb_writes", wr_count - base, 0);
        check("nostrb_reads", rd_count - rbase, 0);

        // Contention after a write: read wins
        spo_val = 32'h0102_0304;
        arid = 12'd6; araddr = 32'h100; arlen = 0; arsize = 2; arburst = 1; arvalid = 1'b1;
        awid = 12'd7; awaddr = 32'h310; awlen = 0; awsize = 2; awburst = 1; awvalid = 1'b1;
        #1;
        check("arb_r_first_ar", arready, 1);
        check("arb_r_first_aw", awready, 0);
        step();
        arvalid = 1'b0;
        r_take(data, resp, lst, id);
        check("arb_r_data", data, 32'h0102_0304);
        #1;
        check("arb_w_next", awready, 1);
        step();
        awvalid = 1'b0;
        w_beat(32'h99, 4'hF, 1'b1);
        b_take(resp, id);
        check("arb_w_bid", id, 12'd7);

        // Error bursts
        base = wr_count; rbase = rd_count;
        aw_go(12'd8, 32'h320, 8'd0, 3'd1, 2'd1);
        w_beat(32'hAAAA, 4'hF, 1'b1);
        b_take(resp, id);
        check("err_size_bresp", resp, 2);
        check("err_size_writes", wr_count - base, 0);
        spo_val = 32'hFFFF_FFFF;
        ar_go(12'd9, 32'h330, 8'd1, 3'd2, 2'd2);
        r_take(data, resp, lst, id);
        check("wrap_b0_data", data, 0);
        check("wrap_b0_resp", resp, 2);
        check("wrap_b0_last", lst, 0);
        r_take(data, resp, lst, id);
        check("wrap_b1_data", data, 0);
        check("wrap_b1_resp", resp, 2);
        check("wrap_b1_last", lst, 1);
        check("wrap_reads", rd_count - rbase, 0);
        aw_go(12'd10, 32'h340, 8'd1, 3'd2, 2'd1);
        w_beat(32'd1, 4'hF, 1'b1);
        w_beat(32'd2, 4'hF, 1'b1);
        b_take(resp, id);
        check("early_wlast_bresp", resp, 2);

        // FIXED burst after the errors: constant address, OKAY response
        base = wr_count;
        aw_go(12'd11, 32'h600, 8'd1, 3'd2, 2'd0);
        w_beat(32'd7, 4'hF, 1'b0);
        w_beat(32'd8, 4'hF, 1'b1);
        b_take(resp, id);
        check("fixed_bresp", resp, 0);
        check("fixed_writes", wr_count - base, 2);
        check("fixed_addr0", wr_addr_log[base % 64], 32'h600);
        check("fixed_addr1", wr_addr_log[(base + 1) % 64], 32'h600);
        check("fixed_data1", wr_data_log[(base + 1) % 64], 32'd8);

        // Reset during beat 2 of a len-7 read, then a clean read
        spo_val = 32'h1111_1111;
        ar_go(12'd12, 32'h400, 8'd7, 3'd2, 2'd1);
        r_take(data, resp, lst, id);
        r_take(data, resp, lst, id);
        wait_cycles = 5;
        #1;
        check("mid_rd", rd, 1);
        check("mid_a", a, 32'h408);
        rst = 1'b0;
        #1;
        check("async_rst_rd", rd, 0);
        check("async_rst_a", a, 0);
        check("async_rst_rdata", rdata, 0);
        step(); step();
        rst = 1'b1;
        wait_cycles = 0;
        spo_val = 32'hCAFE_F00D;
        ar_go(12'd13, 32'h500, 8'd0, 3'd2, 2'd1);
        r_take(data, resp, lst, id);
        check("post_rst_rdata", data, 32'hCAFE_F00D);
        check("post_rst_rresp", resp, 0);
        check("post_rst_rlast", lst, 1);
        check("post_rst_rid", id, 12'd13);

        check("we_rd_exclusive", both_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi42mm.md
# axi42mm

AXI4 slave-to-memory-mapped bridge: the responder counterpart of the pCPU-side AXI4 master bridge. It accepts AXI4 read and write bursts from an external AXI4 master (DMA engine, debug host, second core) and replays them one word at a time as pCPU-style bus accesses (`a`/`d`/`we`/`rd`/`spo`/`ready`). This lets AXI4 initiators reach QuasiSoC peripherals and memory through the existing bus. Byte strobes are honoured by read-modify-write, because the mm bus has no byte enables.

## Interface
- `AXI4_IDLEN`, 12, AXI ID width
- `AXI4_ADDRLEN`, 32, AXI address width (zero-extended or truncated to 32 on `a`)
- `AXI4_DATALEN`, 32, data width; only 32 is supported
- `clk` in 1: the single clock
- `rst` in 1: reset, asynchronous, active-low
- `s_axi_awid/awaddr/awlen/awsize/awburst` in: write address fields; `awlock/awcache/awprot/awqos` in, ignored
- `s_axi_awvalid` in 1, `s_axi_awready` out 1
- `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wlast` in 1, `s_axi_wvalid` in 1, `s_axi_wready` out 1
- `s_axi_bid` out IDLEN, `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1
- `s_axi_arid/araddr/arlen/arsize/arburst` in: read address fields; `arlock/arcache/arprot/arqos` in, ignored
- `s_axi_arvalid` in 1, `s_axi_arready` out 1
- `s_axi_rid` out IDLEN, `s_axi_rdata` out 32, `s_axi_rresp` out 2, `s_axi_rlast` out 1, `s_axi_rvalid` out 1, `s_axi_rready` in 1
- `a` out 32: mm word address, bits [1:0] always 0
- `d` out 32: mm write data
- `we`, `rd` out 1: mm write / read request; held high until `ready`
- `spo` in 32: mm read data, valid when `ready` is high with `rd`
- `ready` in 1: mm access complete

## Operation
- One transaction in flight; no interleaving and no outstanding queue.
- States: IDLE, W_DATA, W_RMW_RD, W_MM, W_RESP, R_MM, R_DATA.
- IDLE arbitration:
  - Both `awvalid` and `arvalid` high: the class not served last wins (round-robin; a flag set on reset favours write).
  - The granted `awready` or `arready` is high for exactly one cycle (the handshake cycle).
  - On the handshake, latch addr, len, id, and burst; clear the beat counter.
- Burst handling:
  - FIXED: address is constant for the whole burst.
  - INCR: address += 4 after each beat.
  - WRAP, or size != 2: error burst. There is no mm access; W beats are drained; `bresp`=SLVERR; reads return `len`+1 beats with `rdata`=0 and `rresp`=SLVERR.
- Write path:
  - W_DATA: `wready`=1; latch `wdata`/`wstrb`/`wlast` on the handshake.
  - Next state by strobe: `wstrb`=F goes to W_MM; `wstrb`=0 skips the mm access; any other value goes to W_RMW_RD.
  - W_RMW_RD: `rd` until `ready`. Merge per byte: strobe byte taken from `wdata`, others from `spo`.
  - W_MM: `we` with `d`=merged data until `ready`.
  - After each beat: if beat==len go to W_RESP, else increment and return to W_DATA.
  - If `wlast` != (beat==len) on any beat, the sticky error makes `bresp`=SLVERR; the beat count still follows `len`.
  - W_RESP: `bvalid`, `bid`=awid; on `bready` go to IDLE.
- Read path:
  - R_MM: `rd` until `ready`; register `spo` into `rdata`.
  - R_DATA: `rvalid`, `rid`=arid, `rlast`=(beat==len), `rresp`=OKAY.
  - On `rready`: last beat goes to IDLE, otherwise increment and go to R_MM.
- All AXI outputs are stable while valid and not yet accepted.

## Timing
- Reset values: all ready/valid/`we`/`rd`/`rlast` = 0; `a`/`d`/`rdata`/ids/resp = 0; state IDLE; arbitration flag = write.
- Read beat latency:
  - Cycle 0: AR handshake.
  - Cycle 1: `rd`=1; with zero-wait `ready` it is accepted the same cycle.
  - Cycle 2: `rvalid`=1.
  - Each further beat costs at least 2 cycles (R_MM then R_DATA).
- Full-strobe write beat: the W handshake is followed by `we` the next cycle.
- `bvalid` comes 1 cycle after the last mm `ready`. Partial-strobe beats add 1 + read-wait cycles.
- `we` and `rd` are never high together. Each drops the cycle after `ready` is sampled high. `ready` arriving while neither is asserted is ignored.
- `len`=255 gives 256 beats. The 8-bit beat counter is compared against `len` and never wraps. Address increments are 32-bit and wrap modulo 2^32; the 4 KB boundary is not checked.
- Reset asserted mid-burst: everything returns to reset values immediately (asynchronously). The burst is abandoned with no response.

## Structure
- Package `axi4_pkg`:
  - burst constants FIXED=0, INCR=1, WRAP=2
  - resp constants OKAY=0, SLVERR=2
  - state enum
  - `SIZE_WORD`=2
- Sub-module `axi4_burst_addr`: holds address and beat counter; provides load, step (FIXED/INCR) and the `last` flag. It is shared by both paths.

## Test plan
- Single read, `araddr`=0x100, len 0, mm returns 0xDEADBEEF with zero wait → `a`=0x100, `rd` for 1 cycle, `rvalid`+`rlast` at cycle 2, `rdata`=0xDEADBEEF, `rresp`=0.
- INCR write, len 3 at 0x200, data 1..4, `wstrb`=F, `ready` delayed 2 cycles → four `we` pulses at 0x200/0x204/0x208/0x20C, `bresp`=0, `bid` echoes `awid`.
- Partial write, `wstrb`=0x3, `wdata`=0x0000ABCD, mm holds 0x12345678 → read then write of 0x1234ABCD; `wstrb`=0 → no mm access, `bresp`=0.
- Simultaneous `awvalid`+`arvalid` after reset → write served first, read next. Repeating this gives alternating order.
- Error bursts: `awsize`=1 → no `we`, `bresp`=2. `arburst`=WRAP, len 1 → two beats with `rdata`=0, `rresp`=2, and `rlast` on the second. Early `wlast` → `bresp`=2.
- Reset pulse during beat 2 of a len-7 read → outputs zero asynchronously; a new AR after release completes normally.
